adder_stream_core: RTL and testbench

//  Streaming adder DUT driven by the adder_intf bench through a valid/ready

---
 rtl/common_pkg.sv | 19 +
 rtl/adder_stream_core_if.sv | 26 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/adder_stream_core.sv | 82 ++++++++
 tb/tb_adder_stream_core.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// Shared constants and operand/result types for the streaming adder.
// Imported by the RTL and by the bench.
package common_pkg;

  localparam int ADD_W  = 4;
  localparam int FIFO_D = 4;

  typedef struct packed {
    logic [ADD_W-1:0] a;
    logic [ADD_W-1:0] b;
  } add_req_t;

  typedef logic [ADD_W:0] add_rsp_t;

  function automatic add_rsp_t add_op(add_req_t r);
    return {1'b0, r.a} + {1'b0, r.b};
  endfunction

endpackage

// File: rtl/adder_stream_core_if.sv
// Operand and result valid/ready channels of the streaming adder.
// The slave modport is the core side, the master modport is the driver.
interface adder_stream_core_if #(
  parameter int WIDTH = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_sum;
  logic [15:0]      txn_count;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, txn_count
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, txn_count
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-two depth, naturally wrapping pointers.
// Head is read combinationally from the storage array.
module sync_fifo #(
  parameter int W = 5,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [W-1:0]         din,
  input  logic                 pop,
  output logic [W-1:0]         dout,
  output logic [$clog2(D):0]   count,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until count is non-zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(D));
  assign empty = (count == '0);

  a_no_push_full: assert property (
    @(posedge clk) disable iff (rst) !(push && full)
  );

  a_no_pop_empty: assert property (
    @(posedge clk) disable iff (rst) !(pop && empty)
  );

endmodule

// File: rtl/adder_stream_core.sv
// Streaming adder: operand stage S1, result FIFO, credit-based in_ready.
// Results are never dropped; in_ready comes from registered occupancy.
module adder_stream_core
  import common_pkg::*;
#(
  parameter int WIDTH = ADD_W,
  parameter int DEPTH = FIFO_D
) (
  input logic               clk,
  input logic               rst,
  adder_stream_core_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             s1_vld;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH:0]   s1_sum;
  logic [WIDTH:0]   head;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occ;
  logic             full;
  logic             empty;
  logic             accept;
  logic             pop;
  logic [15:0]      txn_q;

  // Every accepted pair holds a credit until its result is popped.
  assign occ = {1'b0, fifo_count} + {{CW{1'b0}}, s1_vld};

  assign bus.in_ready = !rst && (occ < (CW+1)'(DEPTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a <= bus.in_a;
        s1_b <= bus.in_b;
      end
    end
  end

  assign s1_sum = {1'b0, s1_a} + {1'b0, s1_b};

  sync_fifo #(
    .W (WIDTH + 1),
    .D (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_vld),
    .din   (s1_sum),
    .pop   (pop),
    .dout  (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_q <= '0;
    end else if (pop) begin
      txn_q <= txn_q + 16'd1;
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_sum   = empty ? '0 : head;
  assign bus.txn_count = txn_q;

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_adder_stream_core.sv
// Directed bench for adder_stream_core with a queue-based reference model
// checked every falling edge, plus hand-computed literal expectations.
module tb_adder_stream_core;
  import common_pkg::*;

  localparam int W = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;

  adder_stream_core_if #(.WIDTH(W)) bus ();

  adder_stream_core #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: accepted pairs waiting for delivery, with the cycle
  // at which each becomes visible at the output.
  typedef struct {
    int sum;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc  = 0;
  int   mtxn = 0;

  always @(negedge clk) begin
    bit ev;
    bit er;
    if (rst) begin
      q.delete();
      mtxn = 0;
      chk("m_rst_in_ready", int'(bus.in_ready), 0);
      chk("m_rst_out_valid", int'(bus.out_valid), 0);
      chk("m_rst_out_sum", int'(bus.out_sum), 0);
      chk("m_rst_txn", int'(bus.txn_count), 0);
    end else begin
      er = (q.size() < D);
      ev = (q.size() > 0) && (q[0].cyc <= cyc);
      chk("m_in_ready", int'(bus.in_ready), int'(er));
      chk("m_out_valid", int'(bus.out_valid), int'(ev));
      chk("m_txn", int'(bus.txn_count), mtxn);
      if (ev) chk("m_out_sum", int'(bus.out_sum), q[0].sum);
      if (ev && bus.out_ready) begin
        void'(q.pop_front());
        mtxn = (mtxn + 1) % 65536;
      end
      if (bus.in_valid && er)
        q.push_back('{sum: int'(bus.in_a) + int'(bus.in_b),
                      cyc: cyc + 2});
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic get_result(input string nm, input int exp);
    int n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_wait"}, int'(n < 20), 1);
    chk(nm, int'(bus.out_sum), exp);
    tick();
  endtask

  initial begin
    #100000;
    fails++;
    $display("FAIL global_timeout: got 0 expected 1");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  int acc;
  int got;
  int got_loop;
  int pa [6];
  int pb [6];

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // Reset
    repeat (2) tick();
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_txn", int'(bus.txn_count), 0);
    rst = 1'b0;
    tick();
    chk("rel_in_ready", int'(bus.in_ready), 1);

    // Single operation
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 4'd3;
    bus.in_b      = 4'd4;
    tick();
    bus.in_valid = 1'b0;
    chk("single_not_yet", int'(bus.out_valid), 0);
    tick();
    chk("single_valid", int'(bus.out_valid), 1);
    chk("single_sum", int'(bus.out_sum), 7);
    tick();
    chk("single_txn", int'(bus.txn_count), 1);
    chk("single_drained", int'(bus.out_valid), 0);

    // Carry
    bus.in_valid = 1'b1;
    bus.in_a     = 4'hF;
    bus.in_b     = 4'h1;
    tick();
    bus.in_a = 4'hF;
    bus.in_b = 4'hF;
    tick();
    bus.in_valid = 1'b0;
    get_result("carry_f1", 'h10);
    get_result("carry_ff", 'h1E);

    // Backpressure
    pa = '{1, 2, 3, 4, 5, 6};
    pb = '{8, 9, 10, 11, 12, 13};
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = W'(pa[acc]);
      bus.in_b     = W'(pb[acc]);
      if (bus.in_ready) acc++;
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("bp_accepted", acc, 4);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    chk("bp_valid", int'(bus.out_valid), 1);
    chk("bp_head", int'(bus.out_sum), 9);
    tick();
    chk("bp_head_stable", int'(bus.out_sum), 9);
    bus.out_ready = 1'b1;
    get_result("bp_r0", 9);
    get_result("bp_r1", 11);
    get_result("bp_r2", 13);
    get_result("bp_r3", 15);
    chk("bp_ready_back", int'(bus.in_ready), 1);

    // Full throughput
    got = 0;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = W'(i);
      bus.in_b     = W'((i * 7) % 16);
      if (bus.out_valid) got++;
      tick();
    end
    got_loop     = got;
    bus.in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (bus.out_valid) got++;
      tick();
    end
    chk("thru_steady", got_loop, 18);
    chk("thru_total", got, 20);

    // Mid-operation reset
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = W'(i);
      bus.in_b     = W'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (2) tick();
    chk("mid_buffered", int'(bus.out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_async_valid", int'(bus.out_valid), 0);
    chk("mid_async_txn", int'(bus.txn_count), 0);
    chk("mid_async_ready", int'(bus.in_ready), 0);
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 4'd2;
    bus.in_b      = 4'd5;
    tick();
    bus.in_valid = 1'b0;
    get_result("post_rst_sum", 7);
    chk("post_rst_txn", int'(bus.txn_count), 1);
    repeat (3) tick();
    chk("post_rst_empty", int'(bus.out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
